// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch lookup is combinational from registered state; EX resolution updates the
// indexed entry on the clock edge and raises a same-cycle redirect on mispredict.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] if_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [63:0] ex_pc,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [63:0] ex_pred_target,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 32;
  localparam logic [1:0]  CTR_RESET = 2'b01;
  localparam logic [1:0]  CTR_ALLOC = 2'b10;
  localparam logic [1:0]  CTR_MAX   = 2'b11;
  localparam logic [1:0]  CTR_MIN   = 2'b00;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // Table storage
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             lk_hit, ex_hit, ex_tag_match;

  logic             wr_en;
  logic             wr_valid_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [PC_W-1:0]  wr_tgt_d;
  logic [1:0]       wr_ctr_d;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[TAG_W+IDX_W+1:IDX_W+2];

  // Fetch-stage lookup; no bypass from a same-cycle update
  always_comb begin
    lk_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = lk_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? tgt_q[if_idx] : (if_pc + PC_W'(4));
  end

  // Mispredict detection and correct next PC, suppressed while in reset
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rstn && ex_valid) begin
      if (ex_is_branch) begin
        redirect = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
      end else begin
        redirect = ex_pred_taken;
      end
    end
    if (redirect) begin
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + PC_W'(4));
    end
  end

  // Next value of the single entry touched by the resolving instruction
  always_comb begin
    ex_tag_match = (tag_q[ex_idx] == ex_tag);
    ex_hit       = valid_q[ex_idx] && ex_tag_match;
    wr_en        = 1'b0;
    wr_valid_d   = valid_q[ex_idx];
    wr_tag_d     = tag_q[ex_idx];
    wr_tgt_d     = tgt_q[ex_idx];
    wr_ctr_d     = ctr_q[ex_idx];
    if (ex_valid) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          wr_en = 1'b1;
          if (ex_taken) begin
            wr_tgt_d = ex_target;
            if (ctr_q[ex_idx] != CTR_MAX) wr_ctr_d = ctr_q[ex_idx] + 2'd1;
          end else begin
            if (ctr_q[ex_idx] != CTR_MIN) wr_ctr_d = ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          wr_en      = 1'b1;
          wr_valid_d = 1'b1;
          wr_tag_d   = ex_tag;
          wr_tgt_d   = ex_target;
          wr_ctr_d   = CTR_ALLOC;
        end
      end else if (ex_pred_taken && ex_tag_match) begin
        // Alias: a non-branch was predicted taken, drop the stale entry
        wr_en      = 1'b1;
        wr_valid_d = 1'b0;
      end
    end
  end

  // Saturating statistics counters
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_valid && ex_is_branch && (branch_cnt_q != CNT_SAT)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (redirect && (mispred_cnt_q != CNT_SAT)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Table state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= wr_valid_d;
      tag_q[ex_idx]   <= wr_tag_d;
      tgt_q[ex_idx]   <= wr_tgt_d;
      ctr_q[ex_idx]   <= wr_ctr_d;
    end
  end

  // Statistics register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver applies directed then random
// stimulus and queues the expected outputs from an abstract table model; a
// monitor pops and compares on the falling edge.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned TAG_W   = 10;
  localparam int unsigned IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] if_pc = '0;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [63:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [63:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [63:0] ex_pred_target = '0;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pt;
    logic [63:0] ptgt;
    logic        rd;
    logic [63:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Abstract model: which (tag) lives at each slot, its target and a 0..3 confidence
  bit          m_valid [ENTRIES];
  longint      m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_conf  [ENTRIES];
  longint      m_bcnt, m_mcnt;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_conf[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  function automatic int slot_of(input logic [63:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint tag_of(input logic [63:0] pc);
    return longint'((pc / (4 * ENTRIES)) % (64'd1 << TAG_W));
  endfunction

  function automatic void cmp64(input string nm, input logic [63:0] act, input logic [63:0] ex);
    n_total++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
  endfunction

  // One cycle: drive inputs, queue expectation, advance the model
  task automatic step(input bit rst, input logic [63:0] ipc, input bit v, input bit br,
                      input logic [63:0] epc, input bit tk, input logic [63:0] etgt,
                      input bit ptk, input logic [63:0] ptgt, input string nm);
    exp_t e;
    int   s;
    bit   hit, mis;
    @(posedge clk);
    #1;
    if_pc = ipc; ex_valid = v; ex_is_branch = br; ex_pc = epc; ex_taken = tk;
    ex_target = etgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    rstn = !rst;
    e.tag = nm;
    if (rst) begin
      model_reset();
      e.pt = 1'b0; e.ptgt = ipc + 64'd4; e.rd = 1'b0; e.rpc = '0; e.bc = '0; e.mc = '0;
      exp_q.push_back(e);
      return;
    end
    s = slot_of(ipc);
    e.pt   = m_valid[s] && (m_tag[s] == tag_of(ipc)) && (m_conf[s] >= 2);
    e.ptgt = e.pt ? m_tgt[s] : ipc + 64'd4;
    mis = v && (br ? ((tk != ptk) || (tk && ptk && etgt != ptgt)) : ptk);
    e.rd  = mis;
    e.rpc = !mis ? 64'd0 : ((br && tk) ? etgt : epc + 64'd4);
    e.bc  = 32'(m_bcnt);
    e.mc  = 32'(m_mcnt);
    exp_q.push_back(e);
    if (v) begin
      s   = slot_of(epc);
      hit = m_valid[s] && (m_tag[s] == tag_of(epc));
      if (br) begin
        if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
        if (hit) begin
          m_conf[s] = tk ? ((m_conf[s] == 3) ? 3 : m_conf[s] + 1)
                         : ((m_conf[s] == 0) ? 0 : m_conf[s] - 1);
          if (tk) m_tgt[s] = etgt;
        end else if (tk) begin
          m_valid[s] = 1'b1; m_tag[s] = tag_of(epc); m_tgt[s] = etgt; m_conf[s] = 2;
        end
      end else if (ptk && m_tag[s] == tag_of(epc)) begin
        m_valid[s] = 1'b0;
      end
      if (mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
    end
  endtask

  task automatic look(input logic [63:0] ipc, input string nm);
    step(0, ipc, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, nm);
  endtask

  task automatic br(input logic [63:0] ipc, input logic [63:0] epc, input bit tk,
                    input logic [63:0] etgt, input bit ptk, input logic [63:0] ptgt,
                    input string nm);
    step(0, ipc, 1, 1, epc, tk, etgt, ptk, ptgt, nm);
  endtask

  function automatic logic [63:0] rnd_pc();
    logic [63:0] p;
    if ($urandom_range(0, 19) == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
    p = 64'h1000 + 64'($urandom_range(0, 3)) * 4 + 64'($urandom_range(0, 2)) * (4 * ENTRIES);
    return p;
  endfunction

  function automatic logic [63:0] rnd_tgt();
    case ($urandom_range(0, 2))
      0:       return 64'h0F00;
      1:       return 64'h2000;
      default: return 64'h3000;
    endcase
  endfunction

  // Monitor: compare the queued expectation against what the DUT shows
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp64({e.tag, " pred_taken"},  64'(pred_taken),  64'(e.pt));
        cmp64({e.tag, " pred_target"}, pred_target,      e.ptgt);
        cmp64({e.tag, " redirect"},    64'(redirect),    64'(e.rd));
        cmp64({e.tag, " redirect_pc"}, redirect_pc,      e.rpc);
        cmp64({e.tag, " branch_cnt"},  64'(branch_cnt),  64'(e.bc));
        cmp64({e.tag, " mispred_cnt"}, 64'(mispred_cnt), 64'(e.mc));
      end
    end
  end

  // Driver
  initial begin
    int wait_cyc;
    model_reset();
    repeat (2) @(posedge clk);
    step(1, 64'h1000, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, "in_reset");
    look(64'h1000, "post_reset");
    br(64'h1000, 64'h1000, 1, 64'h0F00, 0, 64'h0, "alloc_redirect");
    look(64'h1000, "alloc_visible");
    br(64'h1000, 64'h1000, 0, 64'h0, 1, 64'h0F00, "nt1_same_idx");
    br(64'h1000, 64'h1000, 0, 64'h0, 0, 64'h0, "nt2");
    br(64'h1000, 64'h1000, 0, 64'h0, 0, 64'h0, "nt3_sat");
    look(64'h1000, "after_sat");
    br(64'h1010, 64'h1010, 1, 64'h2000, 0, 64'h0, "alloc_1010");
    br(64'h1010, 64'h1010 + ENTRIES * 4, 0, 64'h0, 0, 64'h0, "alias_nt");
    look(64'h1010, "still_hit");
    br(64'h1010, 64'h1010 + ENTRIES * 4, 1, 64'h3000, 0, 64'h0, "alias_tk");
    look(64'h1010, "evicted");
    br(64'h1020, 64'h1020, 1, 64'h2000, 0, 64'h0, "alloc_1020");
    look(64'h1020, "hit_1020");
    step(0, 64'h1020, 1, 0, 64'h1020, 0, 64'h0, 1, 64'h2000, "nonbranch_alias");
    look(64'h1020, "inval_miss");
    br(64'h1000, 64'h1000, 1, 64'h2000, 1, 64'h3000, "tgt_mismatch");
    br(64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 1, 64'h10, "wrap_pc");
    step(1, 64'h1000, 1, 1, 64'h1000, 1, 64'h0F00, 0, 64'h0, "reset_mid_upd");
    look(64'h1000, "post_reset_miss");
    for (int i = 0; i < 600; i++) begin
      bit rs = ($urandom_range(0, 49) == 0);
      step(rs, rnd_pc(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           rnd_pc(), 1'($urandom), rnd_tgt(), 1'($urandom), rnd_tgt(), "rand");
    end
    look(64'h1000, "idle");
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
- REQ-001 Parameter ENTRIES, default 16, number of direct-mapped table entries (power of two).
- REQ-002 Parameter TAG_W, default 10, tag bits stored per entry.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rstn  input  1  reset, asynchronous and active-low.
- REQ-005 if_pc  input  64  fetch-stage PC being looked up.
- REQ-006 pred_taken  output  1  fetch-stage taken prediction for if_pc.
- REQ-007 pred_target  output  64  predicted next PC for if_pc.
- REQ-008 ex_valid  input  1  EX-stage instruction valid and not stalled; gates all updates.
- REQ-009 ex_is_branch  input  1  EX instruction is a conditional branch.
- REQ-010 ex_pc  input  64  EX instruction PC.
- REQ-011 ex_taken  input  1  actual direction; this is the comparator cmp_res.
- REQ-012 ex_target  input  64  actual branch target (ex_pc + imm).
- REQ-013 ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- REQ-014 ex_pred_target  input  64  predicted target carried down the pipe.
- REQ-015 redirect  output  1  mispredict; fetch restarts at redirect_pc and younger stages flush.
- REQ-016 redirect_pc  output  64  correct next PC.
- REQ-017 branch_cnt  output  32  resolved branches since reset.
- REQ-018 mispred_cnt  output  32  redirects since reset.

Function
- REQ-019 Index = pc[IDX_W+1:2] with IDX_W = log2(ENTRIES); tag = pc[TAG_W+IDX_W+1:IDX_W+2].
- REQ-020 Each entry holds valid, tag, 64-bit target and a 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- REQ-021 Lookup is combinational from registered state: hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = pred_taken ? entry target : if_pc + 4.
- REQ-022 Updates occur only on the clock edge where ex_valid = 1; ex_valid = 0 holds all state and forces redirect = 0.
- REQ-023 Branch, update hit: counter increments if ex_taken, else decrements; saturates at 11 and 00; target overwritten with ex_target when ex_taken.
- REQ-024 Branch, update miss, ex_taken = 1: allocate with valid = 1, new tag, target = ex_target, ctr = 10, replacing any previous occupant.
- REQ-025 Branch, update miss, ex_taken = 0: no allocation, table unchanged.
- REQ-026 Non-branch with ex_pred_taken = 1 (alias): invalidate the indexed entry if its tag matches ex_pc.
- REQ-027 Mispredict (combinational, same cycle as ex_valid): branch with ex_taken != ex_pred_taken; branch with ex_taken = ex_pred_taken = 1 and ex_target != ex_pred_target; or non-branch with ex_pred_taken = 1.
- REQ-028 redirect_pc = ex_target for a taken branch, else ex_pc + 4; 64-bit adds wrap modulo 2^64.
- REQ-029 redirect_pc = 0 whenever redirect = 0.
- REQ-030 branch_cnt increments on each valid branch update; mispred_cnt increments on each redirect; both saturate at 0xFFFF_FFFF.
- REQ-031 Lookup and update to the same index in one cycle: lookup returns the pre-update value (no bypass); the update takes effect next cycle.
- REQ-032 Latency: an update is visible to lookup one cycle after its ex_valid edge.

Reset
- REQ-033 rstn low asynchronously clears all valid bits, sets all counters to 01, and zeroes branch_cnt and mispred_cnt.
- REQ-034 During reset, pred_taken = 0, pred_target = if_pc + 4 and redirect = 0.
- REQ-035 Reset asserted mid-update discards the update; the first post-reset lookup misses.

Verification
- REQ-036 After reset, if_pc = 0x1000 -> pred_taken = 0, pred_target = 0x1004; branch_cnt = mispred_cnt = 0.
- REQ-037 EX branch at 0x1000, taken, target 0x0F00, pred 0 -> redirect = 1, redirect_pc = 0x0F00 that cycle; next cycle if_pc = 0x1000 -> pred_taken = 1, pred_target = 0x0F00; mispred_cnt = 1.
- REQ-038 Same branch resolved not-taken 3 times after allocation -> ctr 10 -> 01 -> 00 -> 00 (saturates); lookup pred_taken = 0 from the first decrement onward.
- REQ-039 Branch 0x1000 allocated; branch at 0x1000 + ENTRIES*4 (same index, different tag) not-taken -> no allocation, 0x1000 still hits; if instead taken -> 0x1000 now misses.
- REQ-040 Non-branch at a hitting PC with ex_pred_taken = 1 -> redirect = 1, redirect_pc = ex_pc + 4, entry invalidated; next lookup misses.
- REQ-041 Lookup and update of the same index in one cycle -> pred_taken reflects the old counter; following cycle reflects the new one; rstn pulsed mid-run -> all outputs at reset values immediately.
